// File: rtl/dbus_xfer_scheduler.sv
// ============================================================================
// Module   : dbus_xfer_scheduler
// Purpose  : Arbitrates bytes between a UART FIFO pair and a dbus port.
//            Inbound bus traffic always wins over outbound host traffic.
//            Host-to-bus bursts are broken up by a listen gap.
// Config   : define DBUS_SCHED_WATCHDOG_EN to enable the per-transfer watchdog
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_xfer_scheduler #(
  parameter int unsigned c_CLOCKFREQ  = 4000000,
  parameter int unsigned c_MAXBURST   = 8,
  parameter int unsigned c_GAPCYCLES  = 64,
  parameter int unsigned c_TIMEOUT_US = 2000
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_host_avail,
  input  logic [7:0] i_host_data,
  output logic       o_host_read,
  output logic [7:0] o_bus_data,
  output logic       o_bus_enable,
  input  logic       i_bus_busy,
  input  logic       i_bus_avail,
  input  logic [7:0] i_bus_data,
  output logic       o_bus_read,
  input  logic       i_bus_receiving,
  output logic [7:0] o_tx_data,
  output logic       o_tx_enable,
  input  logic       i_tx_busy,
  output logic       o_bus_reset_req,
  output logic       o_timeout,
  output logic [7:0] o_err_count,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_H_FETCH = 3'd1,
    S_B_SEND  = 3'd2,
    S_B_WAIT  = 3'd3,
    S_B_FETCH = 3'd4,
    S_T_SEND  = 3'd5,
    S_T_WAIT  = 3'd6,
    S_GAP     = 3'd7
  } state_t;

  localparam int unsigned c_BURST_W = $clog2(c_MAXBURST + 1);
  localparam int unsigned c_GAP_W   = $clog2(c_GAPCYCLES + 1);
  localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(c_MAXBURST - 1);
  localparam logic [c_GAP_W-1:0]   c_GAP_LAST   = c_GAP_W'(c_GAPCYCLES - 1);

  state_t               state_q, state_d;
  logic [c_BURST_W-1:0] burst_q, burst_d;
  logic [c_GAP_W-1:0]   gap_q, gap_d;
  logic                 host_avail_q, bus_busy_q, bus_avail_q, bus_rcv_q, tx_busy_q;
  logic                 host_read_q, bus_enable_q, bus_read_q, tx_enable_q;
  logic [7:0]           bus_data_q, tx_data_q;

`ifdef DBUS_SCHED_WATCHDOG_EN
  localparam int unsigned c_WD_LIMIT = c_CLOCKFREQ / 1000000 * c_TIMEOUT_US;
  localparam int unsigned c_WD_W     = $clog2(c_WD_LIMIT + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(c_WD_LIMIT - 1);

  logic [c_WD_W-1:0] wd_q, wd_d;
  logic              wd_fire;
  logic              timeout_q;
  logic [7:0]        err_q;
`endif

  // Register every handshake input once before the FSM looks at it
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      host_avail_q <= 1'b0;
      bus_busy_q   <= 1'b0;
      bus_avail_q  <= 1'b0;
      bus_rcv_q    <= 1'b0;
      tx_busy_q    <= 1'b0;
    end else begin
      host_avail_q <= i_host_avail;
      bus_busy_q   <= i_bus_busy;
      bus_avail_q  <= i_bus_avail;
      bus_rcv_q    <= i_bus_receiving;
      tx_busy_q    <= i_tx_busy;
    end
  end

  // Next-state logic: inbound first, burst/gap bookkeeping, optional watchdog
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus_avail_q) begin
          state_d = S_B_FETCH;
        end else if (host_avail_q && !bus_rcv_q && !bus_busy_q) begin
          state_d = S_H_FETCH;
        end
      end
      S_H_FETCH: if (!host_avail_q) state_d = S_B_SEND;
      S_B_SEND:  if (bus_busy_q) state_d = S_B_WAIT;
      S_B_WAIT: begin
        if (!bus_busy_q) begin
          if (burst_q == c_BURST_LAST) begin
            burst_d = '0;
            state_d = S_GAP;
          end else begin
            burst_d = burst_q + 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // An inbound byte cuts the listen gap short
        if (bus_avail_q) begin
          state_d = S_B_FETCH;
        end else if (gap_q == c_GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_B_FETCH: begin
        burst_d = '0;
        if (!bus_avail_q) state_d = S_T_SEND;
      end
      S_T_SEND: if (tx_busy_q) state_d = S_T_WAIT;
      S_T_WAIT: if (!tx_busy_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef DBUS_SCHED_WATCHDOG_EN
    // TX states are exempt: a stalled UART must never lose an inbound byte
    wd_fire = 1'b0;
    wd_d    = '0;
    if (state_q inside {S_H_FETCH, S_B_SEND, S_B_WAIT, S_B_FETCH}) begin
      if (wd_q == c_WD_LAST) begin
        wd_fire = 1'b1;
        state_d = S_IDLE;
      end else if (state_d == state_q) begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  // State, counters, registered strobes and data latches
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      burst_q      <= '0;
      gap_q        <= '0;
      host_read_q  <= 1'b0;
      bus_enable_q <= 1'b0;
      bus_read_q   <= 1'b0;
      tx_enable_q  <= 1'b0;
      bus_data_q   <= 8'h00;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      gap_q        <= gap_d;
      host_read_q  <= (state_d == S_H_FETCH);
      bus_enable_q <= (state_d == S_B_SEND);
      bus_read_q   <= (state_d == S_B_FETCH);
      tx_enable_q  <= (state_d == S_T_SEND);
      if (state_q == S_IDLE && state_d == S_H_FETCH) bus_data_q <= i_host_data;
      if (state_q != S_B_FETCH && state_d == S_B_FETCH) tx_data_q <= i_bus_data;
    end
  end

`ifdef DBUS_SCHED_WATCHDOG_EN
  // Watchdog counter, one-clock timeout pulse and saturating error count
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= wd_fire;
      if (wd_fire && err_q != 8'hFF) err_q <= err_q + 8'h01;
    end
  end

  assign o_bus_reset_req = timeout_q;
  assign o_timeout       = timeout_q;
  assign o_err_count     = err_q;
`else
  assign o_bus_reset_req = 1'b0;
  assign o_timeout       = 1'b0;
  assign o_err_count     = 8'h00;
`endif

  assign o_host_read  = host_read_q;
  assign o_bus_enable = bus_enable_q;
  assign o_bus_read   = bus_read_q;
  assign o_tx_enable  = tx_enable_q;
  assign o_bus_data   = bus_data_q;
  assign o_tx_data    = tx_data_q;
  assign o_state      = state_q;

endmodule

`default_nettype wire

// File: doc/dbus_xfer_scheduler.md
DBUS_XFER_SCHEDULER -- requirements
Module: dbus_xfer_scheduler

Interface
REQ-001 The block SHALL have parameter c_CLOCKFREQ, default 4000000, clock frequency in Hz.
REQ-002 The block SHALL have parameter c_MAXBURST, default 8, maximum consecutive host-to-bus bytes before a listen gap.
REQ-003 The block SHALL have parameter c_GAPCYCLES, default 64, length of the listen gap in clocks.
REQ-004 The block SHALL have parameter c_TIMEOUT_US, default 2000, per-transfer watchdog limit in microseconds.
REQ-005 Ports SHALL be: i_clock  in  1  sole clock; all logic on its rising edge.
REQ-006 i_reset_n  in  1  reset, synchronous, active-low.
REQ-007 i_host_avail  in  1, i_host_data  in  8, o_host_read  out  1: UART RX FIFO read handshake.
REQ-008 o_bus_data  out  8, o_bus_enable  out  1, i_bus_busy  in  1: dbus send handshake.
REQ-009 i_bus_avail  in  1, i_bus_data  in  8, o_bus_read  out  1, i_bus_receiving  in  1: dbus receive handshake.
REQ-010 o_tx_data  out  8, o_tx_enable  out  1, i_tx_busy  in  1: UART TX FIFO write handshake.
REQ-011 o_bus_reset_req  out  1 (dbus recovery pulse), o_timeout  out  1 (timeout pulse), o_err_count  out  8 (saturating timeout count), o_state  out  3 (current state code).

Function
REQ-012 All handshake inputs (i_host_avail, i_bus_busy, i_bus_avail, i_bus_receiving, i_tx_busy) SHALL pass one register stage before use.
REQ-013 States SHALL be IDLE=0, H_FETCH=1, B_SEND=2, B_WAIT=3, B_FETCH=4, T_SEND=5, T_WAIT=6, GAP=7, driven on o_state.
REQ-014 IDLE SHALL pick inbound first: registered i_bus_avail -> B_FETCH.
REQ-015 Otherwise IDLE SHALL go to H_FETCH when registered i_host_avail=1, i_bus_receiving=0, i_bus_busy=0.
REQ-016 H_FETCH: o_host_read=1 and i_host_data latched on entry; stay until registered i_host_avail=0, then drop o_host_read and go to B_SEND.
REQ-017 B_SEND: o_bus_enable=1 with o_bus_data=latched byte; on registered i_bus_busy=1 drop enable, go to B_WAIT.
REQ-018 B_WAIT: on registered i_bus_busy=0 increment burst counter; if it equals c_MAXBURST clear it and go to GAP, else IDLE.
REQ-019 GAP: wait c_GAPCYCLES clocks, then IDLE; inbound i_bus_avail during GAP SHALL abort the gap to B_FETCH.
REQ-020 B_FETCH: o_bus_read=1, i_bus_data latched into o_tx_data on entry; on registered i_bus_avail=0 drop read, go to T_SEND; burst counter cleared.
REQ-021 T_SEND: o_tx_enable=1 until registered i_tx_busy=1, then T_WAIT; T_WAIT returns to IDLE on registered i_tx_busy=0.
REQ-022 T_SEND SHALL hold indefinitely while TX is stalled (RTS); no inbound byte SHALL be dropped.
REQ-023 Strobes (o_host_read, o_bus_enable, o_bus_read, o_tx_enable) SHALL be mutually exclusive, registered, never asserted in IDLE or GAP.
REQ-024 Latency: o_host_read SHALL assert 2 clocks after i_host_avail rises in IDLE.
REQ-025 o_bus_data and o_tx_data SHALL hold their value until the next latch.

Reset
REQ-026 With i_reset_n=0 at a rising edge: state IDLE, all strobes 0, o_bus_data=0, o_tx_data=0, burst/gap/watchdog counters 0, o_err_count=0, o_bus_reset_req=0, o_timeout=0.
REQ-027 Reset mid-transfer SHALL discard the latched byte and drop strobes on that edge.

Configuration
REQ-028 Macro DBUS_SCHED_WATCHDOG_EN SHALL control the watchdog.
REQ-029 Defined: counter runs in non-IDLE/non-GAP states except T_SEND/T_WAIT; at c_CLOCKFREQ/1000000*c_TIMEOUT_US clocks it pulses o_bus_reset_req and o_timeout for 1 clock, increments o_err_count (saturating at 255), drops strobes, returns to IDLE; counter clears on every state change.
REQ-030 Undefined: no counter logic; o_bus_reset_req, o_timeout, o_err_count tied 0; states wait forever.

Verification
REQ-031 Host byte 0x5A, bus busy acks after 10 clocks -> o_bus_data=0x5A, o_bus_enable high until busy, state returns 0.
REQ-032 i_bus_avail and i_host_avail rise same clock, bus byte 0xC3 -> B_FETCH first, o_tx_data=0xC3, host byte sent after.
REQ-033 10 host bytes queued, default params -> 8 bus sends, 64-clock GAP (o_state=7), then bytes 9-10.
REQ-034 Watchdog on, i_bus_busy never rises, 4 MHz -> o_timeout pulse after 8000 clocks, o_err_count=1, state 0.
REQ-035 i_reset_n low during B_SEND -> o_bus_enable=0 next edge, o_state=0, no byte reissued.
